// File: rtl/clkgate_ctrl.sv
// clkgate_ctrl: sequences the enable of a downstream clock gate (drain idle window, gate, warm-up on wake)
//   i_clk       ungated source clock, rising edge
//   i_rst       synchronous active-high reset
//   i_sleep_req level request to gate the downstream clock
//   i_wake_evt  single-cycle wake pulse, synchronous to i_clk
//   i_busy      downstream activity; high blocks gating
//   o_en        clock-gate enable, 1 = clock running
//   o_gated     1 = downstream clock stopped or still warming up
//   o_state     RUN=0, DRAIN=1, OFF=2, WAKE=3
module clkgate_ctrl #(
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sleep_req,
    input  logic       i_wake_evt,
    input  logic       i_busy,
    output logic       o_en,
    output logic       o_gated,
    output logic [1:0] o_state
);
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_OFF   = 2'd2;
    localparam logic [1:0] S_WAKE  = 2'd3;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    logic [1:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_armed;

    // armed blocks re-gating after a forced wake until the request cycles low
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_armed <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_armed <= i_wake_evt ? 1'b0 : (!i_sleep_req | r_armed);
        end
    end

    // counter is cleared on every exit from a counting state, so it never wraps
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_RUN: begin
                if (i_sleep_req && r_armed && !i_wake_evt) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = '0;
                end
            end
            S_DRAIN: begin
                if (i_wake_evt || !i_sleep_req) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else if (i_busy) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == IDLE_LAST) begin
                    w_state_nxt = S_OFF;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_OFF: begin
                if (i_wake_evt || !i_sleep_req) begin
                    w_state_nxt = S_WAKE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                if (r_cnt == WAKE_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    // outputs depend on the state register alone
    always_comb begin
        o_state = r_state;
        o_en    = r_state != S_OFF;
        o_gated = r_state[1];
    end
endmodule

// File: tb/tb_clkgate_ctrl.sv
// tb_clkgate_ctrl: directed bench with a cycle-level behavioural model and literal checkpoints
module tb_clkgate_ctrl;
    localparam int IDLE = 8;
    localparam int WAKE = 2;

    logic       clk = 1'b0;
    logic       rst, sleep, wake, busy;
    logic       en, gated;
    logic [1:0] st;

    int total = 0;
    int bad   = 0;

    clkgate_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_sleep_req(sleep), .i_wake_evt(wake),
        .i_busy(busy), .o_en(en), .o_gated(gated), .o_state(st)
    );

    always #5 clk = ~clk;

    // model: mode 0 run, 1 drain, 2 off, 3 warm-up; idle streak and warm-up countdown
    int m_mode = 0;
    int m_idle = 0;
    int m_wake_left = 0;
    bit m_armed = 1;
    bit seen = 0;

    always @(posedge clk) begin
        seen = 1;
        if (rst) begin
            m_mode = 0;
            m_armed = 1;
            m_idle = 0;
            m_wake_left = 0;
        end else begin
            case (m_mode)
                0: if (sleep && m_armed && !wake) begin m_mode = 1; m_idle = 0; end
                1: begin
                    if (wake || !sleep) m_mode = 0;
                    else if (busy) m_idle = 0;
                    else begin
                        m_idle++;
                        if (m_idle == IDLE) m_mode = 2;
                    end
                end
                2: if (wake || !sleep) begin m_mode = 3; m_wake_left = WAKE; end
                default: begin
                    m_wake_left--;
                    if (m_wake_left == 0) m_mode = 0;
                end
            endcase
            if (wake) m_armed = 0;
            else if (!sleep) m_armed = 1;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (seen) begin
            chk("cyc_state", {6'd0, st}, 8'(m_mode));
            chk("cyc_en", {7'd0, en}, {7'd0, m_mode != 2});
            chk("cyc_gated", {7'd0, gated}, {7'd0, m_mode >= 2});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_st(input string name, input int s, input int e, input int g);
        chk({name, "_state"}, {6'd0, st}, 8'(s));
        chk({name, "_en"}, {7'd0, en}, 8'(e));
        chk({name, "_gated"}, {7'd0, gated}, 8'(g));
        chk({name, "_model"}, 8'(m_mode), 8'(s));
    endtask

    initial begin
        rst = 1; sleep = 0; wake = 0; busy = 0;
        tick;
        rst = 0;
        expect_st("reset", 0, 1, 0);
        sleep = 1;
        tick;
        expect_st("drain_entry", 1, 1, 0);
        repeat (7) tick;
        expect_st("drain_edge9", 1, 1, 0);
        tick;
        expect_st("off_edge10", 2, 0, 1);
        sleep = 0;
        tick;
        expect_st("wake_by_req", 3, 1, 1);
        tick;
        expect_st("wake_hold", 3, 1, 1);
        tick;
        expect_st("run_after_wake", 0, 1, 0);
        sleep = 1;
        tick;
        expect_st("drain_reentry", 1, 1, 0);
        repeat (5) tick;
        busy = 1;
        tick;
        busy = 0;
        repeat (7) tick;
        expect_st("busy_restart7", 1, 1, 0);
        tick;
        expect_st("busy_restart8", 2, 0, 1);
        wake = 1;
        tick;
        wake = 0;
        expect_st("wake_evt", 3, 1, 1);
        repeat (2) tick;
        expect_st("wake_done", 0, 1, 0);
        repeat (3) tick;
        expect_st("disarmed", 0, 1, 0);
        sleep = 0;
        tick;
        sleep = 1;
        tick;
        expect_st("rearmed", 1, 1, 0);
        repeat (7) tick;
        sleep = 0;
        tick;
        expect_st("drop_at_7", 0, 1, 0);
        sleep = 1;
        tick;
        expect_st("drain_again", 1, 1, 0);
        wake = 1; busy = 1;
        tick;
        wake = 0; busy = 0;
        expect_st("wake_busy", 0, 1, 0);
        tick;
        expect_st("stay_run", 0, 1, 0);
        sleep = 0;
        tick;
        sleep = 1; wake = 1;
        tick;
        wake = 0;
        expect_st("wake_with_rise", 0, 1, 0);
        tick;
        expect_st("no_drain", 0, 1, 0);
        sleep = 0;
        tick;
        sleep = 1;
        tick;
        expect_st("drain4", 1, 1, 0);
        repeat (8) tick;
        expect_st("off4", 2, 0, 1);
        rst = 1;
        tick;
        rst = 0;
        expect_st("rst_in_off", 0, 1, 0);
        tick;
        expect_st("drain_after_rst", 1, 1, 0);
        repeat (3) tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clkgate_ctrl.md
Name: clkgate_ctrl

Overview:
Sequencer that drives the enable (E) pin of a downstream integrated clock gate feeding a clock buffer tree. It gates the downstream clock only after a sleep request and a programmable idle window. It ungates on request withdrawal or a wake event, then holds a warm-up interval before reporting the clock as running. It runs on the ungated source clock, upstream of the gate and buffer tree.

Parameters:
IDLE_CYCLES, 8, consecutive BUSY-low cycles required in DRAIN before gating (legal range 1 to 2^CNT_W).
WAKE_CYCLES, 2, cycles EN is held high in WAKE before GATED deasserts (legal range 1 to 2^CNT_W).
CNT_W, 4, width of the shared idle/wake counter.

Ports:
CLK  input  1  ungated source clock; all logic on rising edge.
RST  input  1  synchronous, active-high reset.
SLEEP_REQ  input  1  level request to gate the downstream clock (4-phase with GATED).
WAKE_EVT  input  1  single-cycle wake pulse, already synchronous to CLK.
BUSY  input  1  downstream activity flag; high means do not gate.
EN  output  1  registered enable to the clock-gate E pin; 1 = clock running.
GATED  output  1  registered status; 1 = downstream clock stopped or not yet warmed up.
STATE  output  2  current FSM state: RUN=0, DRAIN=1, OFF=2, WAKE=3.

Behaviour:
- Reset (RST high at a rising edge): STATE=RUN, EN=1, GATED=0, counter=0, armed=1. Reset has priority over all inputs and aborts any state, including OFF. EN is 1 on the cycle after reset is sampled.
- All outputs are registered and decoded from the state register only. No combinational path from any input to any output.
- armed flag: set whenever SLEEP_REQ=0 is sampled. Cleared when WAKE_EVT=1 is sampled. Prevents re-gating after a forced wake until SLEEP_REQ toggles low and then high.
- RUN: EN=1, GATED=0. If SLEEP_REQ=1 and armed=1 and WAKE_EVT=0, go to DRAIN with counter=0.
- DRAIN: EN=1, GATED=0. Evaluated in this priority order:
  - WAKE_EVT=1: go to RUN and clear armed.
  - SLEEP_REQ=0: go to RUN.
  - BUSY=1: counter=0 and stay in DRAIN.
  - BUSY=0 and counter==IDLE_CYCLES-1: go to OFF.
  - Otherwise: counter+1.
- OFF: EN=0, GATED=1. BUSY is ignored. If WAKE_EVT=1 (also clears armed) or SLEEP_REQ=0, go to WAKE with counter=0.
- WAKE: EN=1, GATED=1. SLEEP_REQ and WAKE_EVT do not change the state here; armed is still updated. When counter==WAKE_CYCLES-1, go to RUN; otherwise counter+1.
- Latency, IDLE_CYCLES=N, BUSY held low:
  - SLEEP_REQ sampled at edge k puts STATE=DRAIN after edge k.
  - EN=0 and GATED=1 after edge k+N.
- Latency, wake with WAKE_CYCLES=W:
  - Trigger sampled at edge j gives EN=1 and STATE=WAKE after edge j.
  - GATED=0 and STATE=RUN after edge j+W.
- Invariant: EN=0 only in OFF. GATED never falls while EN=0. EN never falls without passing through DRAIN.
- Simultaneous events: WAKE_EVT together with SLEEP_REQ rising in RUN means no DRAIN entry (armed cleared). WAKE_EVT together with BUSY in DRAIN goes to RUN.
- Counter never overflows, because every transition out of a counting state resets it.

Test Plan:
- Reset, then SLEEP_REQ=1 at edge 2 with BUSY=0 and IDLE_CYCLES=8 -> STATE=1 after edge 2; EN=0, GATED=1, STATE=2 after edge 10.
- In DRAIN, pulse BUSY=1 when counter=5 -> counter returns to 0; gating occurs 8 edges after BUSY falls; EN stays 1 throughout.
- In OFF, drop SLEEP_REQ at edge j -> EN=1 after edge j; GATED=0 and STATE=0 after edge j+2. Then raise SLEEP_REQ again -> DRAIN re-entered.
- In OFF with SLEEP_REQ held 1, pulse WAKE_EVT -> WAKE then RUN, and STATE stays 0 while SLEEP_REQ stays 1. Drop SLEEP_REQ for 1 cycle and raise it -> DRAIN entered.
- Drop SLEEP_REQ in DRAIN at counter=7 -> STATE=0, EN never 0. Separately, assert WAKE_EVT and BUSY in the same DRAIN cycle -> STATE=0.
- Assert RST while in OFF -> EN=1, GATED=0, STATE=0 after that edge, armed=1; with SLEEP_REQ=1 held, DRAIN is entered on the edge after RST drops.
